mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: EARLY_TERM, default 0, meaning 1 permits CALC to exit once the remaining multiplier bits are all zero.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on rising edge.
REQ-005 op  input  2  00 MUL (32-bit low product), 10 UMULL, 11 SMULL, 01 reserved (treated as MUL).
REQ-006 a  input  32  multiplicand (Rn-side operand).
REQ-007 b  input  32  multiplier (Rm-side operand).
REQ-008 busy  output  1  high while an operation is in progress; the controller holds in its execute state while high.
REQ-009 done  output  1  one-cycle pulse marking result_lo/result_hi/flags valid.
REQ-010 result_lo  output  32  product bits [31:0].
REQ-011 result_hi  output  32  product bits [63:32] for UMULL/SMULL, zero for MUL.
REQ-012 flags  output  2  {N,Z} of the result, for the controller's flag write.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; encoding is free.
REQ-014 In IDLE or DONE, start=1 SHALL latch a, b and op, load the iteration counter with 32, clear the accumulator, and enter CALC.
REQ-015 start SHALL be ignored in CALC and FIX; input changes after acceptance SHALL NOT affect the result.
REQ-016 For SMULL, absolute values of a and b SHALL be latched, plus a negate bit = a[31] XOR b[31]; 0x80000000 SHALL be treated as unsigned 2^31.
REQ-017 CALC SHALL perform one radix-2 shift-add step per cycle: if the multiplier LSB is 1, add the multiplicand into the 64-bit accumulator at the current shift position; shift the multiplier right one bit; decrement the counter.
REQ-018 CALC SHALL exit to FIX when the counter reaches 0, or, with EARLY_TERM=1, when the remaining multiplier is zero after at least one step.
REQ-019 FIX SHALL take one cycle: it two's-complement negates the 64-bit accumulator if op=SMULL and negate=1, zeroes the upper 32 bits if op is MUL/reserved, then enters DONE.
REQ-020 DONE SHALL last one cycle with done=1, then go to IDLE unless start=1 (per REQ-014).
REQ-021 busy SHALL be 1 exactly in CALC and FIX; done SHALL be 1 exactly in DONE.
REQ-022 With EARLY_TERM=0, done SHALL be high in the 34th cycle after the edge that sampled start (32 CALC + 1 FIX + 1 DONE).
REQ-023 result_lo, result_hi and flags SHALL update only on the FIX-to-DONE edge and hold until the next FIX completes.
REQ-024 N SHALL be result_lo[31] for MUL and result_hi[31] for long ops.
REQ-025 Z SHALL be 1 iff result_lo is zero (MUL) or the full 64-bit result is zero (long ops).
REQ-026 The accumulator SHALL be 64 bits wide with carry discarded beyond bit 63; an unsigned 32x32 product cannot overflow it.

Reset
REQ-027 reset=1 SHALL force IDLE with busy=0, done=0, result_lo=0, result_hi=0, flags=00 and counter=0, regardless of state.
REQ-028 Reset asserted mid-operation SHALL abort it, with no done pulse for the aborted operation.
REQ-029 reset SHALL take priority over start in the same cycle.

Verification
REQ-030 MUL a=7, b=6, EARLY_TERM=0 -> busy for 33 cycles, done in cycle 34, result_lo=42, result_hi=0, flags=00.
REQ-031 UMULL a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=10.
REQ-032 SMULL a=0xFFFFFFFF (-1), b=1 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFF, flags=10; SMULL a=b=0x80000000 -> result_hi=0x40000000, result_lo=0, flags=00.
REQ-033 MUL a=0, b=0x12345678 -> result_lo=0, flags=01; with EARLY_TERM=1, MUL a=5, b=1 -> done in cycle 3.
REQ-034 Start MUL 3x3, then pulse start with a=9 at cycle 5 -> ignored, result_lo=9; back-to-back start in the DONE cycle -> accepted, second done 34 cycles later.
REQ-035 Start UMULL, assert reset for one cycle at cycle 10 -> busy=0 and outputs zero the next cycle, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequential 32x32 radix-2 shift-add multiplier for MUL / UMULL / SMULL.
// One multiplier bit is consumed per CALC cycle, then FIX applies sign and width before results are published.
module mul_sequencer #(
    parameter int EARLY_TERM = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic [1:0]  flags
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic        r_long;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [1:0]  r_flags;

    logic        w_smull;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_acc_step;
    logic [31:0] w_mplier_shift;
    logic [5:0]  w_cnt_dec;
    logic        w_calc_exit;
    logic [63:0] w_signed_acc;
    logic [63:0] w_final;
    logic        w_n;
    logic        w_z;

    // Signed operands are multiplied as magnitudes; 0x80000000 negates to itself, i.e. unsigned 2^31.
    assign w_smull = (op == 2'b11);
    assign w_abs_a = (w_smull && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (w_smull && b[31]) ? (32'd0 - b) : b;

    assign w_acc_step     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_shift = r_mplier >> 1;
    assign w_cnt_dec      = r_cnt - 6'd1;
    assign w_calc_exit    = (w_cnt_dec == 6'd0) || ((EARLY_TERM != 0) && (w_mplier_shift == 32'd0));

    assign w_signed_acc = r_neg ? (64'd0 - r_acc) : r_acc;
    assign w_final      = r_long ? w_signed_acc : {32'd0, w_signed_acc[31:0]};
    assign w_n          = r_long ? w_final[63] : w_final[31];
    assign w_z          = r_long ? (w_final == 64'd0) : (w_final[31:0] == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_long   <= 1'b0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= 32'd0;
            r_hi     <= 32'd0;
            r_flags  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {32'd0, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_cnt    <= 6'd32;
                        r_acc    <= 64'd0;
                        r_long   <= op[1];
                        r_neg    <= w_smull && (a[31] ^ b[31]);
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shift;
                    r_cnt    <= w_cnt_dec;
                    if (w_calc_exit) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_final[31:0];
                    r_hi    <= w_final[63:32];
                    r_flags <= {w_n, w_z};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flags     = r_flags;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: one instance with full 32-step iteration, one with early termination.
// A transaction-level model predicts busy/done/result per cycle for both; directed literals pin the model.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [31:0] lo_v [2];
    logic [31:0] hi_v [2];
    logic [1:0]  fl_v [2];

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mul_sequencer #(.EARLY_TERM(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .result_lo(lo_v[0]), .result_hi(hi_v[0]), .flags(fl_v[0])
    );

    mul_sequencer #(.EARLY_TERM(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .result_lo(lo_v[1]), .result_hi(hi_v[1]), .flags(fl_v[1])
    );

    // Model state: m_cyc is the cycle number since acceptance (0 = idle), m_lat the cycle in which done is due.
    int          m_cyc [2] = '{0, 0};
    int          m_lat [2] = '{0, 0};
    logic [31:0] m_lo [2]  = '{32'd0, 32'd0};
    logic [31:0] m_hi [2]  = '{32'd0, 32'd0};
    logic [1:0]  m_fl [2]  = '{2'd0, 2'd0};
    logic [31:0] p_lo [2];
    logic [31:0] p_hi [2];
    logic [1:0]  p_fl [2];

    function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic [1:0] fl);
        logic [63:0] p;
        case (o)
            2'b10:   p = {32'd0, x} * {32'd0, y};
            2'b11:   p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            default: p = {32'd0, x * y};
        endcase
        hi = p[63:32];
        lo = p[31:0];
        fl = o[1] ? {p[63], p == 64'd0} : {p[31], p[31:0] == 32'd0};
    endfunction

    // Latency in cycles from acceptance to done: 32 steps, or only as many as the multiplier magnitude has bits.
    function automatic int lat_of(input int d, input logic [1:0] o, input logic [31:0] y);
        logic [31:0] eff;
        int steps;
        if (d == 0) return 34;
        eff   = (o == 2'b11 && y[31]) ? (32'd0 - y) : y;
        steps = 1;
        for (int i = 0; i < 32; i++) begin
            if (eff[i]) steps = i + 1;
        end
        return steps + 2;
    endfunction

    task automatic model_edge(input int d);
        if (reset) begin
            m_cyc[d] = 0;
            m_lo[d]  = 32'd0;
            m_hi[d]  = 32'd0;
            m_fl[d]  = 2'd0;
        end else if ((m_cyc[d] == 0 || m_cyc[d] == m_lat[d]) && start) begin
            calc(op, a, b, p_hi[d], p_lo[d], p_fl[d]);
            m_lat[d] = lat_of(d, op, b);
            m_cyc[d] = 1;
        end else if (m_cyc[d] == m_lat[d]) begin
            m_cyc[d] = 0;
        end else if (m_cyc[d] > 0) begin
            m_cyc[d] = m_cyc[d] + 1;
            if (m_cyc[d] == m_lat[d]) begin
                m_lo[d] = p_lo[d];
                m_hi[d] = p_hi[d];
                m_fl[d] = p_fl[d];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_edge(d);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    logic eb;
                    logic ed;
                    eb = (m_cyc[d] > 0) && (m_cyc[d] < m_lat[d]);
                    ed = (m_cyc[d] > 0) && (m_cyc[d] == m_lat[d]);
                    n_vec++;
                    if (busy_v[d] !== eb || done_v[d] !== ed || lo_v[d] !== m_lo[d] ||
                        hi_v[d] !== m_hi[d] || fl_v[d] !== m_fl[d]) begin
                        n_fail++;
                        $display("FAIL model dut%0d t=%0t: busy/done/hi/lo/flags got %b %b %h %h %b expected %b %b %h %h %b",
                                 d, $time, busy_v[d], done_v[d], hi_v[d], lo_v[d], fl_v[d],
                                 eb, ed, m_hi[d], m_lo[d], m_fl[d]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Waits (bounded) for done on one instance; returns the cycle number since acceptance.
    task automatic wait_done(input int d, output int n);
        n = 1;
        while (!done_v[d] && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic [1:0] efl);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(0, n);
        check({name, " latency"}, 64'(n), 64'd34);
        check({name, " hi"}, {32'd0, hi_v[0]}, {32'd0, ehi});
        check({name, " lo"}, {32'd0, lo_v[0]}, {32'd0, elo});
        check({name, " flags"}, {62'd0, fl_v[0]}, {62'd0, efl});
        step();
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  fl;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        tbl[0] = '{2'b00, 32'd7,          32'd6,          32'h00000000, 32'd42,       2'b00};
        tbl[1] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 2'b10};
        tbl[2] = '{2'b11, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10};
        tbl[3] = '{2'b11, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 2'b00};
        tbl[4] = '{2'b00, 32'd0,          32'h12345678,   32'h00000000, 32'h00000000, 2'b01};
        tbl[5] = '{2'b01, 32'h00010000,   32'h00010000,   32'h00000000, 32'h00000000, 2'b01};
        tbl[6] = '{2'b11, 32'd7,          32'hFFFFFFFD,   32'hFFFFFFFF, 32'hFFFFFFEB, 2'b10};
        tbl[7] = '{2'b10, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000, 2'b00};
        tbl[8] = '{2'b00, 32'h00010000,   32'h00008000,   32'h00000000, 32'h80000000, 2'b10};
        tbl[9] = '{2'b11, 32'd0,          32'h80000000,   32'h00000000, 32'h00000000, 2'b01};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        check("reset busy", {62'd0, busy_v}, 64'd0);
        check("reset done", {62'd0, done_v}, 64'd0);
        check("reset outputs", {lo_v[0], hi_v[0]}, 64'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1; a = 32'd3; b = 32'd3;
        step();
        start = 1'b0; reset = 1'b0;
        step();
        check("reset priority busy", {62'd0, busy_v}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].hi, tbl[i].lo, tbl[i].fl);
        end

        // Early termination: 5 x 1 finishes after a single CALC step.
        op = 2'b00; a = 32'd5; b = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, n);
        check("early term latency", 64'(n), 64'd3);
        check("early term lo", {32'd0, lo_v[1]}, 64'd5);
        wait_done(0, n);
        step();

        // A start while busy is ignored; a start during DONE is accepted immediately.
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        a = 32'd9; b = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, n);
        check("ignored start lo", {32'd0, lo_v[0]}, 64'd9);
        a = 32'd11; b = 32'd13; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, n);
        check("back-to-back latency", 64'(n), 64'd34);
        check("back-to-back lo", {32'd0, lo_v[0]}, 64'd143);
        step();

        // Reset mid-operation aborts without a done pulse.
        op = 2'b10; a = 32'h0000FFFF; b = 32'h00012345; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", {62'd0, busy_v}, 64'd0);
        check("abort outputs", {lo_v[0], hi_v[0]}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_v != 2'b00) pulses++;
            step();
        end
        check("abort done pulses", 64'(pulses), 64'd0);
        run_vec("after abort", 2'b10, 32'h0000FFFF, 32'h00012345, 32'h00000001, 32'h2343DCBB, 2'b00);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
